// File: rtl/pipelined_adder.sv
// Purpose: WIDTH-bit add split into STAGES = WIDTH/SLICE slices, resolving one slice per stage.
// Latency: STAGES cycles from accept to valid_o, with one add accepted per cycle.
// Backpressure: the whole pipe stalls when valid_o & !ready_i; optional PIPE_ADDER_OVF_EN adds overflow_o.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int STAGES = WIDTH / SLICE;

    logic adv;

    // Bubbles are held in place too, so one global enable stalls the pipe.
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] in_a;
        logic [WIDTH-1:0] in_b;
        logic [WIDTH-1:0] in_s;
        logic [WIDTH-1:0] nxt_s;
        logic [WIDTH-1:0] s_q;
        logic             in_c;
        logic             in_v;
        logic             c_q;
        logic             v_q;
        logic [SLICE:0]   slice_sum;

        if (k == 0) begin : g_head
            assign in_a = a_i;
            assign in_b = b_i;
            assign in_s = '0;
            assign in_c = carry_i;
            assign in_v = valid_i;
        end else begin : g_link
            logic unused_lo;

            assign in_a = g_stage[k-1].g_ops.a_q;
            assign in_b = g_stage[k-1].g_ops.b_q;
            assign in_s = g_stage[k-1].s_q;
            assign in_c = g_stage[k-1].c_q;
            assign in_v = g_stage[k-1].v_q;
            // Operand bits of resolved slices and sum bits not yet resolved are dead here.
            assign unused_lo = ^{in_a[k*SLICE-1:0], in_b[k*SLICE-1:0], in_s[WIDTH-1:k*SLICE]};
        end

        assign slice_sum = {1'b0, in_a[k*SLICE +: SLICE]}
                         + {1'b0, in_b[k*SLICE +: SLICE]}
                         + {{SLICE{1'b0}}, in_c};

        always_comb begin
            nxt_s                    = in_s;
            nxt_s[k*SLICE +: SLICE]  = slice_sum[SLICE-1:0];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= in_v;
                c_q <= slice_sum[SLICE];
                s_q <= nxt_s;
            end
        end

        // The final stage has no successor, so it carries no operands forward.
        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= in_a;
                    b_q <= in_b;
                end
            end
        end
    end

    assign valid_o = g_stage[STAGES-1].v_q;
    assign sum_o   = g_stage[STAGES-1].s_q;
    assign carry_o = g_stage[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    // Sign bits are taken at the last stage's input so the flag lands with sum_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (g_stage[STAGES-1].in_a[WIDTH-1] == g_stage[STAGES-1].in_b[WIDTH-1])
                  && (g_stage[STAGES-1].nxt_s[WIDTH-1] != g_stage[STAGES-1].in_a[WIDTH-1]);
        end
    end

    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a 32/8 instance (4 stages) and a 16/16 instance (1 stage).
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        valid0, ready_o0, cin0, valid_o0, ready0, carry_o0;
    logic [31:0] a0, b0, sum0;
    logic        valid1, ready_o1, cin1, valid_o1, ready1, carry_o1;
    logic [15:0] a1, b1, sum1;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf0, ovf1;
`endif

    integer checks   = 0;
    integer failures = 0;

    pipelined_adder #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ready_o(ready_o0),
        .a_i(a0), .b_i(b0), .carry_i(cin0), .valid_o(valid_o0), .ready_i(ready0),
        .sum_o(sum0), .carry_o(carry_o0)
`ifdef PIPE_ADDER_OVF_EN
        , .overflow_o(ovf0)
`endif
    );

    pipelined_adder #(.WIDTH(16), .SLICE(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ready_o(ready_o1),
        .a_i(a1), .b_i(b1), .carry_i(cin1), .valid_o(valid_o1), .ready_i(ready1),
        .sum_o(sum1), .carry_o(carry_o1)
`ifdef PIPE_ADDER_OVF_EN
        , .overflow_o(ovf1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid0 = 1'b1; a0 = 32'd5; b0 = 32'd6; cin0 = 1'b1; ready0 = 1'b1;
        valid1 = 1'b1; a1 = 16'd7; b1 = 16'd8; cin1 = 1'b1; ready1 = 1'b1;
        step();
        step();
        checks++; if (valid_o0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o0); end
        checks++; if (sum0 !== 32'd0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum0); end
        checks++; if (carry_o0 !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_o0); end
        checks++; if (valid_o1 !== 1'b0 || sum1 !== 16'd0) begin failures++; $display("FAIL reset_single got=%b/%h exp=0/0", valid_o1, sum1); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
`endif
        rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        #1;
        checks++; if (ready_o0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o0); end
        checks++; if (ready_o1 !== 1'b1) begin failures++; $display("FAIL reset_ready_single got=%b exp=1", ready_o1); end
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (valid_o0 !== 1'b0) begin failures++; $display("FAIL reset_idle cycle=%0d got=%b exp=0", n, valid_o0); end
        end
    endtask

    task automatic test_carry_chain();
        a0 = 32'hFFFF_FFFF; b0 = 32'd0; cin0 = 1'b1; valid0 = 1'b1; ready0 = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            if (cyc == 1) begin valid0 = 1'b0; cin0 = 1'b0; end
            checks++;
            if (valid_o0 !== (cyc == 4)) begin failures++; $display("FAIL carry_chain_valid cycle=%0d got=%b exp=%b", cyc, valid_o0, cyc == 4); end
            if (cyc == 4) begin
                checks++; if (sum0 !== 32'd0) begin failures++; $display("FAIL carry_chain_sum got=%h exp=00000000", sum0); end
                checks++; if (carry_o0 !== 1'b1) begin failures++; $display("FAIL carry_chain_cout got=%b exp=1", carry_o0); end
            end
        end
    endtask

    task automatic test_throughput();
        logic exp_v;
        for (int n = 0; n < 14; n++) begin
            if (n < 8) begin
                valid0 = 1'b1; a0 = 32'(n); b0 = 32'h0000_00FF; cin0 = 1'b0;
            end else begin
                valid0 = 1'b0;
            end
            ready0 = 1'b1;
            step();
            exp_v = (n >= 3) && (n <= 10);
            checks++; if (valid_o0 !== exp_v) begin failures++; $display("FAIL throughput_valid cycle=%0d got=%b exp=%b", n, valid_o0, exp_v); end
            if (exp_v) begin
                checks++;
                if (sum0 !== 32'(n - 3) + 32'd255 || carry_o0 !== 1'b0) begin
                    failures++; $display("FAIL throughput_sum cycle=%0d got=%h/%b exp=%h/0", n, sum0, carry_o0, 32'(n - 3) + 32'd255);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [32:0] vexp [10];
        int          tx, rx;
        logic        accept, emit, held_prev, prev_carry;
        logic [31:0] prev_sum;
        for (int i = 0; i < 10; i++) begin
            va[i]   = 32'hFFFF_FF00 + 32'(i * 37);
            vb[i]   = 32'h0000_0100 + 32'(i);
            vexp[i] = {1'b0, va[i]} + {1'b0, vb[i]};
        end
        tx = 0; rx = 0; held_prev = 1'b0; prev_sum = '0; prev_carry = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (rx == 10) break;
            valid0 = (tx < 10);
            a0     = (tx < 10) ? va[tx] : 32'd0;
            b0     = (tx < 10) ? vb[tx] : 32'd0;
            cin0   = 1'b0;
            ready0 = !(n >= 6 && n <= 10);
            #1;
            checks++;
            if (ready_o0 !== !(valid_o0 && !ready0)) begin failures++; $display("FAIL bp_ready cycle=%0d got=%b valid_o=%b", n, ready_o0, valid_o0); end
            if (n >= 6 && n <= 10) begin
                checks++;
                if (valid_o0 !== 1'b1 || ready_o0 !== 1'b0) begin failures++; $display("FAIL bp_stall cycle=%0d got=%b/%b exp=1/0", n, valid_o0, ready_o0); end
            end
            accept = valid0 && ready_o0;
            emit   = valid_o0 && ready0;
            if (emit) begin
                checks++;
                if ({carry_o0, sum0} !== vexp[rx]) begin failures++; $display("FAIL bp_result idx=%0d got=%h exp=%h", rx, {carry_o0, sum0}, vexp[rx]); end
                rx++;
            end
            held_prev  = valid_o0 && !ready0;
            prev_sum   = sum0;
            prev_carry = carry_o0;
            @(posedge clk);
            #1;
            if (accept) tx++;
            if (held_prev) begin
                checks++;
                if (valid_o0 !== 1'b1 || sum0 !== prev_sum || carry_o0 !== prev_carry) begin
                    failures++; $display("FAIL bp_hold cycle=%0d got=%b/%h exp=1/%h", n, valid_o0, sum0, prev_sum);
                end
            end
        end
        checks++; if (rx != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", rx); end
        checks++; if (tx != 10) begin failures++; $display("FAIL bp_accepted got=%0d exp=10", tx); end
        valid0 = 1'b0; ready0 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (valid_o0 !== 1'b0) begin failures++; $display("FAIL bp_duplicate cycle=%0d got=%b exp=0", n, valid_o0); end
        end
    endtask

    task automatic test_midflight_reset();
        ready0 = 1'b1; cin0 = 1'b0;
        valid0 = 1'b1; a0 = 32'd1; b0 = 32'd2;
        step();
        a0 = 32'd3;
        step();
        a0 = 32'd5; rst = 1'b1;
        step();
        checks++;
        if (valid_o0 !== 1'b0 || sum0 !== 32'd0 || carry_o0 !== 1'b0) begin
            failures++; $display("FAIL midreset_flush got=%b/%h/%b exp=0/0/0", valid_o0, sum0, carry_o0);
        end
        rst = 1'b0; valid0 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            step();
            checks++; if (valid_o0 !== 1'b0) begin failures++; $display("FAIL midreset_leak cycle=%0d got=%b exp=0", n, valid_o0); end
        end
        a0 = 32'h1234_5678; b0 = 32'h1111_1111; cin0 = 1'b1; valid0 = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            step();
            if (cyc == 1) begin valid0 = 1'b0; cin0 = 1'b0; end
            checks++;
            if (valid_o0 !== (cyc == 4)) begin failures++; $display("FAIL midreset_new_valid cycle=%0d got=%b exp=%b", cyc, valid_o0, cyc == 4); end
            if (cyc == 4) begin
                checks++;
                if (sum0 !== 32'h2345_678A || carry_o0 !== 1'b0) begin failures++; $display("FAIL midreset_new_sum got=%h/%b exp=2345678a/0", sum0, carry_o0); end
            end
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_overflow();
        logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic [31:0] tb [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0002};
        logic [31:0] ts [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0003};
        logic        tc [3] = '{1'b0, 1'b1, 1'b0};
        logic        tv [3] = '{1'b1, 1'b1, 1'b0};
        ready0 = 1'b1; cin0 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n < 3) begin valid0 = 1'b1; a0 = ta[n]; b0 = tb[n]; end
            else valid0 = 1'b0;
            step();
            if (n >= 3) begin
                checks++;
                if (valid_o0 !== 1'b1 || sum0 !== ts[n-3] || carry_o0 !== tc[n-3] || ovf0 !== tv[n-3]) begin
                    failures++; $display("FAIL ovf_vec idx=%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", n - 3, valid_o0, sum0, carry_o0, ovf0, ts[n-3], tc[n-3], tv[n-3]);
                end
            end
        end
    endtask
`endif

    task automatic test_single_stage();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h1234};
        logic [15:0] tb [3] = '{16'h0001, 16'h0001, 16'h4321};
        logic        ti [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] ts [3] = '{16'h0000, 16'h8000, 16'h5556};
        logic        tc [3] = '{1'b1, 1'b0, 1'b0};
`ifdef PIPE_ADDER_OVF_EN
        logic        tv [3] = '{1'b0, 1'b1, 1'b0};
`endif
        ready1 = 1'b1;
        checks++; if (valid_o1 !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", valid_o1); end
        for (int n = 0; n < 4; n++) begin
            if (n < 3) begin valid1 = 1'b1; a1 = ta[n]; b1 = tb[n]; cin1 = ti[n]; end
            else valid1 = 1'b0;
            step();
            checks++;
            if (valid_o1 !== (n < 3)) begin failures++; $display("FAIL single_latency cycle=%0d got=%b exp=%b", n, valid_o1, n < 3); end
            if (n < 3) begin
                checks++;
                if (sum1 !== ts[n] || carry_o1 !== tc[n]) begin failures++; $display("FAIL single_sum idx=%0d got=%h/%b exp=%h/%b", n, sum1, carry_o1, ts[n], tc[n]); end
`ifdef PIPE_ADDER_OVF_EN
                checks++;
                if (ovf1 !== tv[n]) begin failures++; $display("FAIL single_ovf idx=%0d got=%b exp=%b", n, ovf1, tv[n]); end
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; ready0 = 1'b1;
        valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; ready1 = 1'b1;
        test_reset();
        test_carry_chain();
        test_throughput();
        test_back_pressure();
        test_midflight_reset();
`ifdef PIPE_ADDER_OVF_EN
        test_overflow();
`endif
        test_single_stage();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
